// File: rtl/rd84_popcount_scheduler.sv
// rd84_popcount_scheduler
// Shares one combinational rd84 8-input popcount unit among NUM_REQ
// requesters. A round-robin arbiter accepts one word at a time, streams it
// through the shared unit one byte per cycle (LSB chunk first), sums the
// per-chunk counts and returns the total with the requester ID on a
// valid/ready response port.
//
// Optional feature (compile-time macro RD84_ERR_CHECK_EN):
//   defined   -> adds o_err_sticky, set when the rd84 result exceeds 8 in
//                a RUN cycle and cleared only by reset; the offending
//                result is accumulated saturated at 8.
//   undefined -> no o_err_sticky port; results are accumulated unchecked.
module rd84_popcount_scheduler #(
    parameter  int NUM_REQ = 4,
    parameter  int WORD_W  = 32,
    localparam int ID_W    = $clog2(NUM_REQ),
    localparam int CNT_W   = $clog2(WORD_W + 1)
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*WORD_W-1:0] i_req_data,
    output logic [7:0]                o_pc_in,
    input  logic [3:0]                i_pc_out,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [ID_W-1:0]           o_rsp_id,
    output logic [CNT_W-1:0]          o_rsp_count
`ifdef RD84_ERR_CHECK_EN
    ,
    output logic                      o_err_sticky
`endif
);

    localparam int NUM_CHUNK = WORD_W / 8;
    localparam int CHUNK_W   = (NUM_CHUNK > 1) ? $clog2(NUM_CHUNK) : 1;
    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNK - 1);
    localparam logic [ID_W-1:0]    LAST_ID    = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [CHUNK_W-1:0] r_chunk_idx;
    logic [WORD_W-1:0]  r_word;
    logic [CNT_W-1:0]   r_acc;
    logic [ID_W-1:0]    r_rsp_id;
    logic [CNT_W-1:0]   r_rsp_count;

    logic               w_grant_valid;
    logic [ID_W-1:0]    w_grant_id;
    logic [ID_W-1:0]    w_scan_id;
    logic [WORD_W-1:0]  w_grant_word;
    logic               w_accept;
    logic               w_last_chunk;
    logic [3:0]         w_pc_val;
    logic [CNT_W-1:0]   w_acc_sum;

    assign w_accept     = (r_state == S_IDLE) && w_grant_valid;
    assign w_last_chunk = (r_chunk_idx == LAST_CHUNK);

    // Round-robin scan: first valid requester starting at r_rr_ptr, wrapping.
    // NOTE: every signal driven in an always_comb gets a default at the top,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = '0;
        w_scan_id     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan_id = ID_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_grant_valid && i_req_valid[w_scan_id]) begin
                w_grant_valid = 1'b1;
                w_grant_id    = w_scan_id;
            end
        end
    end

    // Select the granted requester's word for capture.
    always_comb begin
        w_grant_word = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (w_grant_id == ID_W'(r)) begin
                w_grant_word = i_req_data[r*WORD_W +: WORD_W];
            end
        end
    end

    // Value added to the accumulator for the current chunk.
`ifdef RD84_ERR_CHECK_EN
    logic w_pc_bad;
    assign w_pc_bad = (i_pc_out > 4'd8);
    assign w_pc_val = w_pc_bad ? 4'd8 : i_pc_out;
`else
    assign w_pc_val = i_pc_out;
`endif
    assign w_acc_sum = r_acc + CNT_W'(w_pc_val);

    // FSM state register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (w_grant_valid) w_next_state = S_RUN;
            S_RUN:   if (w_last_chunk)  w_next_state = S_RESP;
            S_RESP:  if (i_rsp_ready)   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: grant one-hot in IDLE, chunk to rd84 in RUN, valid in RESP.
    always_comb begin
        o_req_ready = '0;
        o_pc_in     = 8'h00;
        o_rsp_valid = 1'b0;
        unique case (r_state)
            S_IDLE:  if (w_grant_valid) o_req_ready[w_grant_id] = 1'b1;
            S_RUN:   o_pc_in = r_word[{r_chunk_idx, 3'b000} +: 8];
            S_RESP:  o_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Control and result registers: pointer, chunk index, accumulator, response.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rr_ptr    <= '0;
            r_chunk_idx <= '0;
            r_acc       <= '0;
            r_rsp_id    <= '0;
            r_rsp_count <= '0;
        end else if (w_accept) begin
            r_rr_ptr    <= (w_grant_id == LAST_ID) ? '0 : w_grant_id + ID_W'(1);
            r_chunk_idx <= '0;
            r_acc       <= '0;
            r_rsp_id    <= w_grant_id;
        end else if (r_state == S_RUN) begin
            r_acc       <= w_acc_sum;
            r_chunk_idx <= w_last_chunk ? '0 : r_chunk_idx + CHUNK_W'(1);
            if (w_last_chunk) begin
                r_rsp_count <= w_acc_sum;
            end
        end
    end

    // Captured request word; later req_data changes cannot disturb a job.
    // NOTE: r_word carries no reset -- it is pure datapath, only read in RUN,
    // and always loaded on the accept edge before that.
    always_ff @(posedge i_clock) begin
        if (w_accept) begin
            r_word <= w_grant_word;
        end
    end

`ifdef RD84_ERR_CHECK_EN
    // Sticky flag for an out-of-range rd84 result seen during RUN.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_err_sticky <= 1'b0;
        end else if ((r_state == S_RUN) && w_pc_bad) begin
            o_err_sticky <= 1'b1;
        end
    end
`endif

    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_count = r_rsp_count;

endmodule
